rr_bus_arbiter: RTL and testbench
=================================

// Module: rr_bus_arbiter
// PURPOSE
//  Round-robin bus arbiter for the shared bus. It sits between the masters' request lines and
//  the bus mux select, replacing fixed-priority grant logic with a fair scheme.
//  - Registered one-hot grant.
//  - Tenure held while the owner keeps requesting, capped at MAX_HOLD cycles.
//  - Mandatory one-cycle turnaround between tenures.
// PARAMETERS
//  N_REQ     4   number of requesting masters (>=2)
//  MAX_HOLD  16  max consecutive cycles a single grant may stay high (>=1)
//  IDX_W     2   width of owner index, = clog2(N_REQ)
// PORTS
//  Clock      in   1      rising-edge clock
//  Resetn     in   1      asynchronous, active-low reset
//  i_request  in   N_REQ  level request per master, bit k = master k
//  o_grant    out  N_REQ  registered one-hot grant, all-zero when bus idle
//  o_owner    out  IDX_W  index of current/last granted master
//  o_busy     out  1      high exactly when o_grant != 0
//  o_expired  out  1      one-cycle pulse: tenure forcibly ended by MAX_HOLD
// BEHAVIOUR
//  Reset (Resetn=0, async): state=IDLE, o_grant=0, o_owner=0, o_busy=0, o_expired=0,
//   rr pointer=0 (master 0 highest priority), hold counter=0.
//  States: IDLE, GRANT, TURN.
//  IDLE: on a clock edge with i_request!=0, pick the first set bit scanning circularly from the
//   pointer (ptr, ptr+1, ... mod N_REQ).
//   - Load o_grant one-hot, o_owner=index, counter=1; go to GRANT.
//   - Latency: request sampled at edge k -> grant visible after edge k.
//   - With i_request==0, stay in IDLE.
//  GRANT: per edge, evaluated in this order:
//   1) i_request[o_owner]==0 -> o_grant=0, go to TURN. No pulse.
//   2) else if counter==MAX_HOLD -> o_grant=0, o_expired=1 for that cycle, go to TURN.
//   3) else counter++, hold the grant.
//   - Grant is high for at most MAX_HOLD cycles per tenure.
//   - Requests from non-owners during GRANT are ignored; no preemption.
//   - On any exit from GRANT: pointer = (o_owner+1) mod N_REQ.
//  TURN: exactly one cycle with o_grant=0; the bus is never granted in back-to-back cycles to
//   different masters. The TURN edge arbitrates exactly like IDLE, using the updated pointer:
//   - requests present -> GRANT;
//   - none -> IDLE.
//  Expired master: if it still requests, it competes normally with lowest priority. If it is the
//   only requester, it is re-granted after the single TURN cycle.
//  o_owner keeps its last value while idle. o_busy = |o_grant, registered with it.
//  Counter width clog2(MAX_HOLD+1); it never wraps.
//  Boundary cases:
//   - MAX_HOLD=1: every tenure lasts 1 cycle. o_expired pulses whenever the owner is still
//     requesting.
//   - Simultaneous owner-drop and count==MAX_HOLD: treat as a drop; no pulse.
//   - Reset mid-tenure: grant drops immediately (asynchronous), pointer returns to 0.
//  Multi-hot or X grant is never legal.
// STRUCTURE
//  Shared include bus_arb_defs.vh:
//   - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_TURN=2'd2;
//   - clog2 function shared with other bus blocks.
//  Sub-module rr_pick: purely combinational circular priority picker.
//   - in:  req[N_REQ], ptr[IDX_W]
//   - out: valid, idx[IDX_W], onehot[N_REQ]
//  The top holds the FSM, pointer, counter and output registers.
// TESTING (N_REQ=4, MAX_HOLD=4)
//  1) Resetn=0, i_request=4'b0010 for 5 cycles -> o_grant=0, o_busy=0. Release reset ->
//     o_grant=4'b0010, o_owner=1 after the first rising edge.
//  2) i_request=4'b1111 held -> grant pattern 0001 x4, 0 x1, 0010 x4, 0 x1, 0100 x4, 0 x1,
//     1000 x4, 0 x1, then 0001 again. o_expired pulses in each gap cycle.
//  3) Master 0 granted, drops its request after 2 grant cycles -> o_grant=0 on the next edge,
//     o_expired stays 0, pointer=1.
//  4) Only master 3 requesting, held for 12 cycles -> 0001000-style pattern for bit 3:
//     4 high, 1 low, 4 high, 1 low, 2 high. o_expired pulses twice.
//  5) Owner 2 released, then i_request=4'b0101 -> o_grant=4'b0001 (pointer 3 skips to 0), not
//     4'b0100.
//  6) Resetn pulsed low mid-tenure of master 1 -> o_grant=0 without a clock edge. After release
//     with 4'b1010 requesting -> master 1 (0010) granted first, since the pointer reset to 0.
//  Bench asserts every cycle:
//   - o_grant one-hot or zero;
//   - o_busy == |o_grant;
//   - o_grant is never nonzero in two consecutive cycles with different values.

Source files
------------

// File: rtl/rr_bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding and
// a constant-evaluable ceiling log2 used to size counters.
package rr_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned pow;
    int unsigned res;
    pow = 1;
    res = 0;
    while (pow < value) begin
      pow = pow << 1;
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first set request bit at or after
// ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    pos    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
    if (valid) begin
      onehot = N_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant, tenure capped at
// MAX_HOLD cycles, and a mandatory one-cycle turnaround between tenures.
module rr_bus_arbiter
  import rr_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned IDX_W    = 2
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [N_REQ-1:0] i_request,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_owner,
  output logic             o_busy,
  output logic             o_expired
);

  localparam int unsigned CNT_W = clog2(MAX_HOLD + 1);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [N_REQ-1:0] grant_d;
  logic [IDX_W-1:0] owner_d;
  logic             expired_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  logic             owner_req;
  logic             at_cap;
  logic [IDX_W-1:0] ptr_after_owner;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (i_request),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign owner_req       = i_request[o_owner];
  assign at_cap          = (cnt_q == CNT_W'(MAX_HOLD));
  assign ptr_after_owner = (o_owner == IDX_W'(N_REQ - 1)) ? '0 : o_owner + IDX_W'(1);

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; IDLE and TURN arbitrate identically
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_TURN: state_d = pick_valid ? ST_GRANT : ST_IDLE;
      ST_GRANT:         if (!owner_req || at_cap) state_d = ST_TURN;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs, pointer and hold counter
  always_comb begin
    grant_d   = o_grant;
    owner_d   = o_owner;
    expired_d = 1'b0;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        grant_d = pick_onehot;
        if (pick_valid) begin
          owner_d = pick_idx;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          grant_d = '0;
          ptr_d   = ptr_after_owner;
        end else if (at_cap) begin
          grant_d   = '0;
          expired_d = 1'b1;
          ptr_d     = ptr_after_owner;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: grant_d = '0;
    endcase
  end

  // Output, pointer and counter registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      o_grant   <= '0;
      o_owner   <= '0;
      o_busy    <= 1'b0;
      o_expired <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
    end else begin
      o_grant   <= grant_d;
      o_owner   <= owner_d;
      o_busy    <= |grant_d;
      o_expired <= expired_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_rr_bus_arbiter;

  localparam int unsigned N_REQ    = 4;
  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned IDX_W    = 2;

  logic             Clock;
  logic             Resetn;
  logic [N_REQ-1:0] i_request;
  logic [N_REQ-1:0] o_grant;
  logic [IDX_W-1:0] o_owner;
  logic             o_busy;
  logic             o_expired;

  int n_tests;
  int n_fail;

  // Model: the bus is either held by one master (grant != 0) or free, in which
  // case the next edge arbitrates from the rotating pointer.
  logic [N_REQ-1:0] m_grant;
  int               m_owner;
  int               m_hold;
  int               m_ptr;
  logic             m_exp;
  logic [N_REQ-1:0] prev_grant;

  rr_bus_arbiter #(
    .N_REQ    (N_REQ),
    .MAX_HOLD (MAX_HOLD),
    .IDX_W    (IDX_W)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .i_request (i_request),
    .o_grant   (o_grant),
    .o_owner   (o_owner),
    .o_busy    (o_busy),
    .o_expired (o_expired)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grant    = '0;
    m_owner    = 0;
    m_hold     = 0;
    m_ptr      = 0;
    m_exp      = 1'b0;
    prev_grant = '0;
  endtask

  task automatic model_edge(input logic [N_REQ-1:0] req);
    logic [N_REQ-1:0] r;
    m_exp = 1'b0;
    if (m_grant != '0) begin
      r = req >> m_owner;
      if (!r[0] || m_hold == MAX_HOLD) begin
        m_exp   = r[0];
        m_grant = '0;
        m_ptr   = (m_owner + 1) % N_REQ;
      end else begin
        m_hold++;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        int c;
        c = (m_ptr + k) % N_REQ;
        r = req >> c;
        if (r[0]) begin
          m_grant = N_REQ'(1) << c;
          m_owner = c;
          m_hold  = 1;
          break;
        end
      end
    end
  endtask

  task automatic check_invariants();
    check("onehot0", 32'($onehot0(o_grant)), 32'd1);
    check("busy_or", 32'(o_busy), 32'(|o_grant));
    check("b2b", 32'(prev_grant != '0 && o_grant != '0 && prev_grant != o_grant), 32'd0);
    prev_grant = o_grant;
  endtask

  // One clock edge with req applied; outputs compared #1 after the edge
  task automatic step(input logic [N_REQ-1:0] req);
    i_request = req;
    @(posedge Clock);
    model_edge(req);
    #1;
    check("grant", 32'(o_grant), 32'(m_grant));
    check("owner", 32'(o_owner), 32'(m_owner));
    check("busy", 32'(o_busy), 32'(m_grant != '0));
    check("expired", 32'(o_expired), 32'(m_exp));
    check_invariants();
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Resetn    = 1'b0;
    i_request = '0;
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_owner", 32'(o_owner), 32'd0);
    Resetn = 1'b1;
  endtask

  int exp_cnt;
  int high_cnt;
  logic [N_REQ-1:0] rnd_req;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    Resetn    = 1'b0;
    i_request = 4'b0010;
    model_reset();

    // 1) Held in reset with a request pending, then released
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check("t1_rst_grant", 32'(o_grant), 32'd0);
      check("t1_rst_busy", 32'(o_busy), 32'd0);
    end
    Resetn = 1'b1;
    step(4'b0010);
    check("t1_grant", 32'(o_grant), 32'b0010);
    check("t1_owner", 32'(o_owner), 32'd1);

    // 2) All masters requesting: rotating capped tenures
    do_reset();
    exp_cnt  = 0;
    high_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b1111);
      exp_cnt  += int'(o_expired);
      high_cnt += int'(o_busy);
    end
    check("t2_expired", 32'(exp_cnt), 32'd4);
    check("t2_high", 32'(high_cnt), 32'd16);
    step(4'b1111);
    check("t2_wrap", 32'(o_grant), 32'b0001);

    // 3) Owner drops early: no pulse, pointer moves to 1
    do_reset();
    step(4'b0001);
    step(4'b0001);
    step(4'b0000);
    check("t3_drop", 32'(o_grant), 32'd0);
    check("t3_noexp", 32'(o_expired), 32'd0);
    step(4'b0011);
    check("t3_ptr", 32'(o_grant), 32'b0010);

    // 4) Lone master 3 re-granted after each expiry
    do_reset();
    exp_cnt  = 0;
    high_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(4'b1000);
      exp_cnt  += int'(o_expired);
      high_cnt += int'(o_grant[3]);
    end
    check("t4_expired", 32'(exp_cnt), 32'd2);
    check("t4_high", 32'(high_cnt), 32'd10);

    // 5) Pointer after owner 2 wraps past 3 to 0
    do_reset();
    step(4'b0100);
    step(4'b0000);
    step(4'b0101);
    check("t5_wrap", 32'(o_grant), 32'b0001);

    // 6) Asynchronous reset mid-tenure
    do_reset();
    step(4'b0010);
    step(4'b0010);
    #2;
    Resetn = 1'b0;
    #1;
    check("t6_async_grant", 32'(o_grant), 32'd0);
    check("t6_async_busy", 32'(o_busy), 32'd0);
    model_reset();
    @(negedge Clock);
    Resetn = 1'b1;
    step(4'b1010);
    check("t6_after", 32'(o_grant), 32'b0010);

    // Random traffic with sticky requests
    do_reset();
    rnd_req = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = N_REQ'($urandom);
      step(rnd_req);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
